bcd_digit_counter: RTL
======================

# bcd_digit_counter

Receiving end of the `inc_clk`/`ref_clk` pulse interface produced by the debounced input trigger stage. Holds a DIGITS-wide BCD count, adds the per-digit increments requested on `inc_clk` with a ripple carry processed one digit per clock, and on `ref_clk` snapshots the count and shifts it out serially to the external display shift register. It sits between the trigger stage and the display pins.

## Interface
- `DIGITS`, 6, number of BCD digits (4 bits each); count width W = 4*DIGITS
- `clk` in 1, system clock
- `rst_n` in 1, asynchronous active-low reset
- `inc_clk` in 1, single-cycle increment request pulse
- `digit_sel` in DIGITS, digits to increment by 1; sampled only in the cycle `inc_clk`=1
- `ref_clk` in 1, single-cycle refresh request pulse
- `clear` in 1, synchronous clear of count and overflow
- `count` out W, live BCD count, digit 0 in bits [3:0]
- `disp` out W, snapshot of `count` taken on refresh
- `busy` out 1, high while the add sequence runs
- `overflow` out 1, sticky; set on carry out of the top digit
- `ser_data` out 1, serial display data
- `ser_valid` out 1, high on each cycle `ser_data` carries a bit
- `ser_latch` out 1, single-cycle latch strobe after the last bit

## Operation
- Reset: all outputs 0, `count`=`disp`=0, state IDLE, pending-refresh flag 0.
- States: IDLE, ADD, SHIFT, LATCH.
- IDLE + `inc_clk`: latch `digit_sel` into `sel_q`, carry=0, digit index i=0, go to ADD.
- ADD: each cycle, digit i <= digit i + `sel_q[i]` + carry. A sum ≥10 stores sum-10 with carry=1; otherwise carry=0. Maximum sum 9+1+1=11, so carry never exceeds 1. After i=DIGITS-1, a carry of 1 sets `overflow` (digit wraps normally) and the FSM goes to IDLE.
- IDLE + `ref_clk`, or IDLE with pending-refresh set: `disp` <= `count`, clear pending, go to SHIFT.
- If `inc_clk` and `ref_clk` arrive in the same IDLE cycle, the increment wins and the refresh becomes pending.
- `ref_clk` during ADD sets pending-refresh, so the snapshot always reflects the completed add.
- SHIFT: W cycles with `ser_valid`=1. `ser_data` = `disp` bit W-1-k on the k-th cycle (MSB first). Then go to LATCH.
- LATCH: `ser_latch`=1 for one cycle, then go to IDLE.
- `inc_clk` outside IDLE is ignored (dropped).
- `ref_clk` during SHIFT or LATCH is ignored.
- `clear`, in any state:
  - sets `count`=0 and `overflow`=0;
  - if in ADD, aborts to IDLE;
  - has priority over an `inc_clk` in the same cycle (that increment is dropped);
  - leaves `disp`, the shift sequence and pending-refresh untouched.
- Digit values 10–15 never occur. Behaviour is defined only for legal BCD.

## Timing
- `inc_clk` high in IDLE cycle T: `busy`=1 for cycles T+1..T+DIGITS. Digit i is updated at the end of cycle T+1+i. `count` is final and `overflow` valid from cycle T+DIGITS+1, and the FSM is back in IDLE then. With DIGITS=6 this is 7 cycles, within the 10-cycle gap before `ref_clk`.
- `ref_clk` high in IDLE cycle R: `disp` valid from R+1. `ser_valid`=1 for R+1..R+W. `ser_latch`=1 at R+W+1. IDLE at R+W+2.
- Pending refresh: the snapshot is taken in the first IDLE cycle after ADD ends, then the sequence above applies.
- `ser_data` and `ser_valid` are 0 whenever the state is not SHIFT.
- `rst_n` low mid-sequence: immediate return to the reset values, with no partial `ser_latch`.

## Test plan
- Reset, then `inc_clk` with `digit_sel`=000001 ×3 (spaced) → `count`=0x000003, `busy` high exactly 6 cycles each time, `overflow`=0.
- `count`=0x000999, `inc_clk` with `digit_sel`=000001 → `count`=0x001000 at T+7.
- `count`=0x000099, `digit_sel`=000011 → `count`=0x000110.
- `count`=0x999999, `digit_sel`=000001 → `count`=0x000000 and `overflow`=1. `clear` → `overflow`=0.
- `count`=0x123456, `ref_clk` → `disp`=0x123456. `ser_valid` is high 24 cycles, and the `ser_data` stream equals 0001_0010_0011_0100_0101_0110. `ser_latch` pulses once at R+25.
- `ref_clk` 2 cycles after `inc_clk` (from 0x000009, `digit_sel`=000001) → snapshot deferred, `disp`=0x000010. A second `inc_clk` during SHIFT is dropped and `count` is unchanged. `rst_n` low during SHIFT → `ser_valid`=0 immediately and all outputs 0.

Source files
------------

// File: rtl/bcd_digit_counter_if.sv
// ---------------------------------------------------------------------------
// bcd_digit_counter_if
// Bundles the request pulses coming from the trigger stage and the count /
// serial display outputs of the BCD digit counter.
//   master : drives inc_clk, digit_sel, ref_clk, clear; observes the outputs
//   slave  : the counter itself; consumes the requests, drives count, disp,
//            busy, overflow, ser_data, ser_valid, ser_latch
// ---------------------------------------------------------------------------
interface bcd_digit_counter_if #(
    parameter int DIGITS = 6
);
    localparam int W = 4 * DIGITS;

    logic              inc_clk;
    logic [DIGITS-1:0] digit_sel;
    logic              ref_clk;
    logic              clear;
    logic [W-1:0]      count;
    logic [W-1:0]      disp;
    logic              busy;
    logic              overflow;
    logic              ser_data;
    logic              ser_valid;
    logic              ser_latch;

    modport master (
        output inc_clk, digit_sel, ref_clk, clear,
        input  count, disp, busy, overflow, ser_data, ser_valid, ser_latch
    );

    modport slave (
        input  inc_clk, digit_sel, ref_clk, clear,
        output count, disp, busy, overflow, ser_data, ser_valid, ser_latch
    );
endinterface

// File: rtl/bcd_digit_counter.sv
// ---------------------------------------------------------------------------
// bcd_digit_counter
// Holds a DIGITS-wide BCD count. An inc_clk pulse adds 1 to every digit
// selected in digit_sel, rippling the carry one digit per clock. A ref_clk
// pulse snapshots the count into disp and shifts it out MSB first, followed
// by a one-cycle latch strobe.
// Ports:
//   clk, rst_n : system clock, asynchronous active-low reset
//   bus        : slave side of bcd_digit_counter_if (requests in, count,
//                snapshot, status and serial display signals out)
// ---------------------------------------------------------------------------
module bcd_digit_counter #(
    parameter int DIGITS = 6
) (
    input  logic                  clk,
    input  logic                  rst_n,
    bcd_digit_counter_if.slave    bus
);
    localparam int W     = 4 * DIGITS;
    localparam int IDX_W = $clog2(DIGITS);
    localparam int BIT_W = $clog2(W);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(W - 1);

    typedef enum logic [1:0] {IDLE, ADD, SHIFT, LATCH} state_t;

    state_t             r_state;
    state_t             w_nextState;
    logic [W-1:0]       r_count;
    logic [W-1:0]       r_disp;
    logic [DIGITS-1:0]  r_selQ;
    logic               r_carry;
    logic [IDX_W-1:0]   r_idx;
    logic               r_pending;
    logic               r_overflow;
    logic [BIT_W-1:0]   r_bitCnt;

    logic               w_startAdd;
    logic               w_startShift;
    logic [3:0]         w_digit;
    logic [4:0]         w_sum;
    logic               w_wrap;
    logic [3:0]         w_newDigit;
    logic [BIT_W-1:0]   w_serIdx;
    logic               w_busy;
    logic               w_serData;
    logic               w_serValid;
    logic               w_serLatch;

    // An increment wins over a refresh in the same IDLE cycle; clear drops
    // the increment, in which case a simultaneous refresh may still start.
    assign w_startAdd   = (r_state == IDLE) && bus.inc_clk && !bus.clear;
    assign w_startShift = (r_state == IDLE) && !w_startAdd
                          && (bus.ref_clk || r_pending);

    // One digit of the ripple add: 9+1+1 is the largest sum, so a single
    // subtract of 10 and a 1-bit carry are enough.
    assign w_digit    = r_count[r_idx*4 +: 4];
    assign w_sum      = {1'b0, w_digit} + {4'b0, r_selQ[r_idx]} + {4'b0, r_carry};
    assign w_wrap     = (w_sum >= 5'd10);
    assign w_newDigit = w_wrap ? 4'(w_sum - 5'd10) : w_sum[3:0];

    assign w_serIdx   = LAST_BIT - r_bitCnt;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_nextState;
    end

    // Next-state logic.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE: begin
                if (w_startAdd)        w_nextState = ADD;
                else if (w_startShift) w_nextState = SHIFT;
            end
            ADD: begin
                if (bus.clear || (r_idx == LAST_IDX)) w_nextState = IDLE;
            end
            SHIFT: begin
                if (r_bitCnt == LAST_BIT) w_nextState = LATCH;
            end
            LATCH:   w_nextState = IDLE;
            default: w_nextState = IDLE;
        endcase
    end

    // Outputs decoded from the state only, so a reset drops them at once.
    always_comb begin
        w_busy     = 1'b0;
        w_serData  = 1'b0;
        w_serValid = 1'b0;
        w_serLatch = 1'b0;
        case (r_state)
            ADD:   w_busy = 1'b1;
            SHIFT: begin
                w_serValid = 1'b1;
                w_serData  = r_disp[w_serIdx];
            end
            LATCH: w_serLatch = 1'b1;
            default: ;
        endcase
    end

    // Add sequencer: selected digits, carry and digit index.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_selQ  <= '0;
            r_carry <= 1'b0;
            r_idx   <= '0;
        end else if (w_startAdd) begin
            r_selQ  <= bus.digit_sel;
            r_carry <= 1'b0;
            r_idx   <= '0;
        end else if (r_state == ADD) begin
            r_carry <= w_wrap;
            r_idx   <= r_idx + 1'b1;
        end
    end

    // Count and sticky overflow; clear overrides any add in progress.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else if (bus.clear) begin
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else if (r_state == ADD) begin
            r_count[r_idx*4 +: 4] <= w_newDigit;
            if ((r_idx == LAST_IDX) && w_wrap) r_overflow <= 1'b1;
        end
    end

    // Deferred refresh: remembered when a refresh collides with an add,
    // consumed when the snapshot is finally taken.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pending <= 1'b0;
        end else if (w_startShift) begin
            r_pending <= 1'b0;
        end else if (bus.ref_clk && (w_startAdd || (r_state == ADD))) begin
            r_pending <= 1'b1;
        end
    end

    // Snapshot register and serial bit counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_disp   <= '0;
            r_bitCnt <= '0;
        end else begin
            if (w_startShift) r_disp <= r_count;
            if (r_state == SHIFT) r_bitCnt <= r_bitCnt + 1'b1;
            else                  r_bitCnt <= '0;
        end
    end

    assign bus.count     = r_count;
    assign bus.disp      = r_disp;
    assign bus.busy      = w_busy;
    assign bus.overflow  = r_overflow;
    assign bus.ser_data  = w_serData;
    assign bus.ser_valid = w_serValid;
    assign bus.ser_latch = w_serLatch;
endmodule
